// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared state encoding and default widths for the step sequencer
package step_seq_pkg;
  localparam int STEPS_W_DEF = 16;
  localparam int TIME_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, TRIG_HI, WAIT_HI, TRIG_LO, WAIT_LO, DRAIN, DONE} Step_seq_state;
endpackage

// File: rtl/step_seq_fsm.sv
// step_seq_fsm: phase sequencing FSM driving the timer trigger/working handshake
// Ports: clk/reset/clk_en timing; start, zero_steps, last_step, abort, timer_working
// condition inputs; busy/done/step/timer_trigger Moore outputs; sel_hi/sel_lo pick the
// timer load; load_cmd, dec_step, abort_done are enabled-edge strobes for the datapath.
module step_seq_fsm
  import step_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic start,
  input  logic zero_steps,
  input  logic last_step,
  input  logic abort,
  input  logic timer_working,
  output logic busy,
  output logic done,
  output logic step,
  output logic timer_trigger,
  output logic sel_hi,
  output logic sel_lo,
  output logic load_cmd,
  output logic dec_step,
  output logic abort_done
);
  Step_seq_state state_q, state_d;
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else if (clk_en) state_q <= state_d;
  end
  // abort outranks every handshake transition so a completing phase is not counted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (zero_steps ? DONE : TRIG_HI) : IDLE;
      TRIG_HI: state_d = abort ? DRAIN : timer_working ? WAIT_HI : TRIG_HI;
      WAIT_HI: state_d = abort ? DRAIN : timer_working ? WAIT_HI : TRIG_LO;
      TRIG_LO: state_d = abort ? DRAIN : timer_working ? WAIT_LO : TRIG_LO;
      WAIT_LO: state_d = abort ? DRAIN : timer_working ? WAIT_LO : last_step ? DONE : TRIG_HI;
      DRAIN:   state_d = timer_working ? DRAIN : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sel_hi = state_q == TRIG_HI;
  assign sel_lo = state_q == TRIG_LO;
  assign step = sel_hi || state_q == WAIT_HI;
  assign timer_trigger = sel_hi || sel_lo;
  assign load_cmd = clk_en && state_q == IDLE && start;
  assign dec_step = clk_en && state_q == WAIT_LO && !timer_working && !abort;
  assign abort_done = clk_en && state_q == DRAIN && !timer_working;
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: emits N step pulses, each phase timed by an external trigger/working timer
// Ports: clk, reset (sync, active-high), clk_en tick enable; start/num_steps/dir/high_time/
// low_time command (latched on start), abort; busy/done/aborted/steps_left status;
// timer_trigger/timer_load/timer_working timer handshake; step/dir_out motor pins.
// Move duration: each phase costs its timer interval plus 2 enabled cycles of handshake,
// so one step takes high_time + low_time + 4 enabled cycles.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int STEPS_W = STEPS_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic [STEPS_W-1:0] num_steps,
  input  logic               dir,
  input  logic [TIME_W-1:0]  high_time,
  input  logic [TIME_W-1:0]  low_time,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [STEPS_W-1:0] steps_left,
  output logic               timer_trigger,
  output logic [TIME_W-1:0]  timer_load,
  input  logic               timer_working,
  output logic               step,
  output logic               dir_out
);
  logic [STEPS_W-1:0] steps_left_q;
  logic [TIME_W-1:0] high_q, low_q;
  logic dir_q, aborted_q, sel_hi, sel_lo, load_cmd, dec_step, abort_done;
  step_seq_fsm u_fsm (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .zero_steps(num_steps == '0), .last_step(steps_left_q == STEPS_W'(1)),
    .abort(abort), .timer_working(timer_working), .busy(busy), .done(done),
    .step(step), .timer_trigger(timer_trigger), .sel_hi(sel_hi), .sel_lo(sel_lo),
    .load_cmd(load_cmd), .dec_step(dec_step), .abort_done(abort_done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      steps_left_q <= '0;
      high_q <= '0;
      low_q <= '0;
      dir_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (load_cmd) begin
        steps_left_q <= num_steps;
        high_q <= high_time;
        low_q <= low_time;
        dir_q <= dir;
        aborted_q <= 1'b0;
      end
      if (dec_step) steps_left_q <= steps_left_q - STEPS_W'(1);
      if (abort_done) aborted_q <= 1'b1;
    end
  end
  assign steps_left = steps_left_q;
  assign aborted = aborted_q;
  assign dir_out = dir_q;
  assign timer_load = sel_hi ? high_q : sel_lo ? low_q : '0;
endmodule

// File: doc/step_sequencer.md
# step_sequencer

Initiator side of the timer trigger/working handshake. Accepts a move command of N steps and emits a stepper-motor step waveform. Each step consists of a high phase and a low phase, and each phase is timed by an external down-counting timer. The block sits between the motion controller and the timer/motor driver pins. It issues `timer_trigger` together with a load value, then tracks `timer_working` to sequence the phases.

## Interface
Parameters:
- `STEPS_W`, 16: width of the step count.
- `TIME_W`, 16: width of the phase duration (timer load value).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `clk_en`, in, 1: tick enable. The same enable drives the timer.
- `start`, in, 1: command strobe. Sampled on a `clk_en` edge in IDLE only.
- `num_steps`, in, STEPS_W: step count. Latched on start.
- `dir`, in, 1: direction. Latched on start.
- `high_time`, in, TIME_W: high-phase duration. Latched on start.
- `low_time`, in, TIME_W: low-phase duration. Latched on start.
- `abort`, in, 1: stop after the current timer interval completes.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: high in DONE state.
- `aborted`, out, 1: qualifies `done`. Set when the move ended by abort.
- `steps_left`, out, STEPS_W: steps not yet completed.
- `timer_trigger`, out, 1: request to the timer.
- `timer_load`, out, TIME_W: value the timer loads on trigger.
- `timer_working`, in, 1: timer busy flag.
- `step`, out, 1: step pin.
- `dir_out`, out, 1: latched direction.

## Operation
- State register advances only on edges where `clk_en`=1. It holds otherwise.
- States: IDLE, TRIG_HI, WAIT_HI, TRIG_LO, WAIT_LO, DRAIN, DONE.
- IDLE:
  - If `start` and `num_steps`≠0: latch operands, set `steps_left`=`num_steps`, go to TRIG_HI.
  - If `start` and `num_steps`=0: go to DONE directly, `aborted`=0.
- TRIG_HI: `timer_trigger`=1, `timer_load`=latched `high_time`, `step`=1. Go to WAIT_HI when `timer_working`=1.
- WAIT_HI: `step`=1, `timer_trigger`=0. Go to TRIG_LO when `timer_working`=0.
- TRIG_LO: `timer_trigger`=1, `timer_load`=latched `low_time`, `step`=0. Go to WAIT_LO when `timer_working`=1.
- WAIT_LO: when `timer_working`=0, decrement `steps_left`.
  - If the pre-decrement value was 1: go to DONE.
  - Otherwise: go to TRIG_HI.
- abort, sampled on a `clk_en` edge in any busy state except DONE:
  - From TRIG_x: go to DRAIN. `timer_trigger` drops.
  - From WAIT_x: go to DRAIN.
- DRAIN:
  - `step`=0.
  - `timer_trigger`=0.
  - Go to DONE with `aborted`=1 once `timer_working`=0.
  - DRAIN covers a timer that accepted a trigger just before the abort, so the block never returns to IDLE while the timer is running.
- DONE: `done`=1. Always go to IDLE on the next `clk_en` edge. `aborted` holds its value until the next start.
- `start` outside IDLE is ignored. No queuing.
- abort is ignored in IDLE and DONE. When abort and a phase completion occur together, abort wins: go to DRAIN, `steps_left` is not decremented.
- `timer_load` is 0 in IDLE, DRAIN and DONE.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `aborted`, `step`, `timer_trigger` = 0.
  - `steps_left`, `timer_load` = 0.
  - `dir_out` = 0.
- Reset mid-move returns to IDLE on the next edge. Reset overrides `clk_en`.
- `step`, `busy`, `done` and `dir_out` decode from registered state/latches only. No input-to-output combinational paths.
- `timer_trigger` is a Moore output of TRIG_x. It is held until `timer_working` is observed high. With a one-cycle-latency timer, trigger is high for 2 enabled cycles.
- Latency with `clk_en`=1, `start` at edge k:
  - TRIG_HI and `busy` from k+1.
  - Timer working at k+2.
  - WAIT_HI at k+3.
- Per step overhead beyond the timer intervals is fixed: 2 enabled cycles per phase. Document this for the duration calculation.
- `steps_left` is updated on the exit edge from WAIT_LO.

## Structure
- `step_seq_pkg`: the state enum `Step_seq_state` and the `STEPS_W`/`TIME_W` defaults.
- Split into two parts:
  - Sub-module `step_seq_fsm`: state register, next-state and output decode.
  - Top: operand latches and the `steps_left` counter.
  - The FSM outputs `load_cmd` and `dec_step` to the top.

## Test plan
Bench instantiates the existing timer FSM plus a down-counter as the responder, with `clk_en`=1 unless stated.
- `num_steps`=3, `high_time`=4, `low_time`=6 → 3 `step` pulses, each high for 4+2 cycles. `done` asserts once. `steps_left` goes 3→0. `aborted`=0.
- `num_steps`=0 → `done` pulse 2 cycles after start. No `timer_trigger`. `step` stays 0.
- `abort` during WAIT_HI of step 2 of 5 → `step` low after the timer expires. `done` with `aborted`=1. `steps_left`=4.
- `abort` in the same cycle that TRIG_LO first sees `timer_working`=1 → DRAIN waits the full `low_time` before `done`. No further trigger.
- `clk_en` toggled 1-in-3, `num_steps`=2 → identical waveform stretched 3×. State frozen on disabled cycles.
- `reset` in WAIT_LO → all outputs 0 next cycle. New start afterwards completes normally once the timer has gone idle.
